// File: rtl/jtag_host_driver.sv
// jtag_host_driver: single-clock JTAG host that turns one-word commands into
// complete TAP walks (test-logic-reset, IR scan, DR scan) on TCK/TMS/TDI and
// captures TDO during the scan periods.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (accepted in IDLE or DONE)
//   cmd_type                 00 TLR, 01 IR scan, 10 DR scan, 11 no-op
//   cmd_len, cmd_data        scan length (clamped to 1..MAX_BITS) and TDI bits
//   resp_valid               one-cycle completion pulse
//   resp_data, resp_err      captured TDO bits, TDO-enable-low flag
//   jtag_clk/modesel/datain  TCK / TMS / TDI
//   jtag_dataout(_en)        TDO and its enable
module jtag_host_driver #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned MAX_BITS = 64,
  parameter int unsigned LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_type,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                resp_valid,
  output logic [MAX_BITS-1:0] resp_data,
  output logic                resp_err,
  output logic                jtag_clk,
  output logic                jtag_modesel,
  output logic                jtag_datain,
  input  logic                jtag_dataout,
  input  logic                jtag_dataout_en
);

  localparam int unsigned PER_W = $clog2(MAX_BITS + 7);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] T_TLR = 2'b00;
  localparam logic [1:0] T_IR  = 2'b01;
  localparam logic [1:0] T_NOP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          typ_q, typ_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                cmd_ready_q, cmd_ready_d, resp_valid_q, resp_valid_d;
  logic [MAX_BITS-1:0] resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  int unsigned         n_acc;

  // Effective scan length: 0 -> 1, anything above MAX_BITS -> MAX_BITS.
  function automatic int unsigned clamp_len(logic [LEN_W-1:0] len);
    if (len == '0) return 1;
    if (32'(len) > MAX_BITS) return MAX_BITS;
    return 32'(len);
  endfunction

  // TCK periods of a walk starting and ending in Run-Test/Idle.
  function automatic int unsigned periods(logic [1:0] typ, int unsigned n);
    if (typ == T_TLR) return 6;
    if (typ == T_IR) return n + 6;
    return n + 5;
  endfunction

  function automatic int unsigned pre_len(logic [1:0] typ);
    return (typ == T_IR) ? 4 : 3;
  endfunction

  function automatic logic is_scan(logic [1:0] typ, int unsigned n, int unsigned p);
    return (typ != T_TLR) && (p >= pre_len(typ)) && (p < pre_len(typ) + n);
  endfunction

  // TMS for period p: preamble to Shift, Exit1 on the last scan bit, Update, RTI.
  function automatic logic tms_at(logic [1:0] typ, int unsigned n, int unsigned p);
    int unsigned pre;
    pre = pre_len(typ);
    if (typ == T_TLR) return p < 5;
    if (p < pre) return (typ == T_IR) ? (p < 2) : (p == 0);
    if (p < pre + n) return p == pre + n - 1;
    return p == pre + n;
  endfunction

  // TDI is MSB-first during scan periods and 0 elsewhere.
  function automatic logic tdi_at(logic [1:0] typ, int unsigned n,
                                  logic [MAX_BITS-1:0] data, int unsigned p);
    logic [MAX_BITS-1:0] sh;
    if (!is_scan(typ, n, p)) return 1'b0;
    sh = data >> (n - 1 - (p - pre_len(typ)));
    return sh[0];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      typ_q        <= T_NOP;
      len_q        <= '0;
      data_q       <= '0;
      per_q        <= '0;
      div_q        <= '0;
      tck_q        <= 1'b0;
      tms_q        <= 1'b1;
      tdi_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      typ_q        <= typ_d;
      len_q        <= len_d;
      data_q       <= data_d;
      per_q        <= per_d;
      div_q        <= div_d;
      tck_q        <= tck_d;
      tms_q        <= tms_d;
      tdi_q        <= tdi_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state: command acceptance, TCK divider, TMS/TDI launch, TDO capture.
  always_comb begin
    state_d      = state_q;
    typ_d        = typ_q;
    len_d        = len_q;
    data_d       = data_q;
    per_d        = per_q;
    div_d        = div_q;
    tck_d        = tck_q;
    tms_d        = tms_q;
    tdi_d        = tdi_q;
    cmd_ready_d  = cmd_ready_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    n_acc        = clamp_len(cmd_len);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          typ_d  = cmd_type;
          len_d  = LEN_W'(n_acc);
          data_d = cmd_data;
          if (cmd_type == T_NOP) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
          end else begin
            state_d     = S_RUN;
            cmd_ready_d = 1'b0;
            per_d       = '0;
            div_d       = '0;
            tck_d       = 1'b0;
            tms_d       = tms_at(cmd_type, n_acc, 0);
            tdi_d       = tdi_at(cmd_type, n_acc, cmd_data, 0);
            resp_data_d = '0;
            resp_err_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        // TDO is stable through the high phase; capture in its first cycle.
        if (tck_q && div_q == '0 && is_scan(typ_q, 32'(len_q), 32'(per_q))) begin
          resp_data_d = {resp_data_q[MAX_BITS-2:0], jtag_dataout};
          if (!jtag_dataout_en) resp_err_d = 1'b1;
        end
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!tck_q) begin
            tck_d = 1'b1;
          end else if (32'(per_q) == periods(typ_q, 32'(len_q)) - 1) begin
            state_d      = S_DONE;
            tck_d        = 1'b0;
            tdi_d        = 1'b0;
            cmd_ready_d  = 1'b1;
            resp_valid_d = 1'b1;
          end else begin
            // Falling edge: launch the next period's TMS/TDI.
            per_d = per_q + PER_W'(1);
            tck_d = 1'b0;
            tms_d = tms_at(typ_q, 32'(len_q), 32'(per_q) + 1);
            tdi_d = tdi_at(typ_q, 32'(len_q), data_q, 32'(per_q) + 1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready    = cmd_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign jtag_clk     = tck_q;
  assign jtag_modesel = tms_q;
  assign jtag_datain  = tdi_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Bench for jtag_host_driver: directed commands, a TDO pattern source keyed on
// observed TCK rising edges, and a scoreboard of expected responses, TMS/TDI
// traces and completion latency.
module tb_jtag_host_driver;

  localparam int unsigned CD = 2;
  localparam int unsigned MB = 64;
  localparam int unsigned LW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = 2'b11;
  logic [LW-1:0] cmd_len = '0;
  logic [MB-1:0] cmd_data = '0;
  logic          resp_valid;
  logic [MB-1:0] resp_data;
  logic          resp_err;
  logic          jtag_clk, jtag_modesel, jtag_datain;
  logic          jtag_dataout, jtag_dataout_en;

  always #5 clk = ~clk;

  jtag_host_driver #(.CLK_DIV(CD), .MAX_BITS(MB), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .jtag_clk(jtag_clk), .jtag_modesel(jtag_modesel), .jtag_datain(jtag_datain),
    .jtag_dataout(jtag_dataout), .jtag_dataout_en(jtag_dataout_en)
  );

  typedef struct {
    logic [MB-1:0] data;
    logic          err;
    int            p;
    int            lat;
    logic [127:0]  tms;
    logic [127:0]  tdi;
  } exp_t;

  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0, acc_cnt = 0, rise_cnt = 0, resp_cnt = 0, resp_cyc = 0;
  logic [127:0] tr_tms = '0, tr_tdi = '0;
  logic tck_prev = 1'b0;
  logic [MB-1:0] cur_pat = '0, nxt_pat = '0;
  int cur_pre = 0, cur_n = 0, cur_errp = -1, nxt_pre = 0, nxt_n = 0, nxt_errp = -1;
  logic [MB-1:0] last_data = '0;
  logic last_err = 1'b0;
  int k_tdo;
  logic [MB-1:0] s_tdo;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle count, TCK rising-edge trace and acceptance tracking.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    tck_prev <= jtag_clk;
    if (jtag_clk && !tck_prev) begin
      tr_tms[7'(rise_cnt)] <= jtag_modesel;
      tr_tdi[7'(rise_cnt)] <= jtag_datain;
      rise_cnt <= rise_cnt + 1;
    end
    if (!rst && cmd_valid && cmd_ready) begin
      acc_cyc  <= cyc;
      acc_cnt  <= acc_cnt + 1;
      rise_cnt <= 0;
      tr_tms   <= '0;
      tr_tdi   <= '0;
      cur_pat  <= nxt_pat;
      cur_pre  <= nxt_pre;
      cur_n    <= nxt_n;
      cur_errp <= nxt_errp;
    end
  end

  // TDO source: period index = rising edges seen; pattern shifted out MSB-first.
  always_comb begin
    k_tdo = rise_cnt - cur_pre;
    s_tdo = '0;
    if (k_tdo >= 0 && k_tdo < cur_n) s_tdo = cur_pat >> (cur_n - 1 - k_tdo);
    jtag_dataout    = s_tdo[0];
    jtag_dataout_en = (rise_cnt != cur_errp);
  end

  // Response checker against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic [127:0] mask;
    if (!rst && resp_valid) begin
      resp_cnt++;
      resp_cyc = cyc;
      if (sb.size() == 0) begin
        chk("resp_unexpected", 128'(sb.size()), 128'(1));
      end else begin
        e = sb.pop_front();
        mask = (128'(1) << e.p) - 128'(1);
        chk("resp_data", 128'(resp_data), 128'(e.data));
        chk("resp_err", 128'(resp_err), 128'(e.err));
        chk("latency", 128'(cyc - acc_cyc), 128'(e.lat));
        chk("tck_periods", 128'(rise_cnt), 128'(e.p));
        chk("tms_trace", tr_tms & mask, e.tms);
        chk("tdi_trace", tr_tdi & mask, e.tdi);
        chk("ready_in_done", 128'(cmd_ready), 128'(1));
      end
    end
  end

  // Build expectation, drive a command and wait (bounded) for its acceptance.
  task automatic send(input logic [1:0] t, input logic [LW-1:0] len, input logic [MB-1:0] d,
                      input logic [MB-1:0] pat, input int errp, input bit push, input bit hold);
    int n, pre, old;
    exp_t e;
    n   = (len == 0) ? 1 : ((int'(len) > int'(MB)) ? int'(MB) : int'(len));
    pre = (t == 2'b01) ? 4 : 3;
    e.tms = '0;
    e.tdi = '0;
    e.data = '0;
    e.err = 1'b0;
    if (t == 2'b00) begin
      e.p = 6;
      e.tms = 128'b011111;
    end else if (t == 2'b11) begin
      e.p = 0;
      e.data = last_data;
      e.err = last_err;
    end else begin
      e.p = pre + n + 2;
      e.tms[0] = 1'b1;
      if (t == 2'b01) e.tms[1] = 1'b1;
      e.tms[7'(pre + n - 1)] = 1'b1;
      e.tms[7'(pre + n)] = 1'b1;
      for (int k = 0; k < n; k++) e.tdi[7'(pre + k)] = d[6'(n - 1 - k)];
      e.data = (n == int'(MB)) ? pat : (pat & ((64'(1) << n) - 64'(1)));
      e.err = (errp >= pre) && (errp < pre + n);
    end
    e.lat = (t == 2'b11) ? 1 : 1 + 2 * int'(CD) * e.p;
    if (push) begin
      sb.push_back(e);
      last_data = e.data;
      last_err = e.err;
    end
    nxt_pat  = pat;
    nxt_pre  = pre;
    nxt_n    = (t == 2'b00 || t == 2'b11) ? 0 : n;
    nxt_errp = errp;
    cmd_type = t;
    cmd_len  = len;
    cmd_data = d;
    cmd_valid = 1'b1;
    old = acc_cnt;
    for (int i = 0; i < 300 && acc_cnt == old; i++) @(negedge clk);
    if (acc_cnt == old) chk("accept_timeout", 128'(acc_cnt), 128'(old + 1));
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 600 && resp_cnt < target; i++) @(negedge clk);
    @(negedge clk);
    if (resp_cnt < target) chk("resp_timeout", 128'(resp_cnt), 128'(target));
  endtask

  initial begin
    int rc, rr;
    repeat (3) @(negedge clk);
    chk("rst_tck", 128'(jtag_clk), 128'(0));
    chk("rst_tms", 128'(jtag_modesel), 128'(1));
    chk("rst_tdi", 128'(jtag_datain), 128'(0));
    chk("rst_ready", 128'(cmd_ready), 128'(1));
    chk("rst_valid", 128'(resp_valid), 128'(0));
    chk("rst_data", 128'(resp_data), 128'(0));
    chk("rst_err", 128'(resp_err), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Test-logic-reset walk.
    send(2'b00, 7'd0, '0, '0, -1, 1'b1, 1'b0);
    chk("tlr_ready_low", 128'(cmd_ready), 128'(0));
    chk("tlr_first_tms", 128'(jtag_modesel), 128'(1));
    wait_resp(1);

    // DR loopback pattern, IR select, full-width DR read.
    send(2'b10, 7'd8, 64'hA5, 64'h3C, -1, 1'b1, 1'b0);
    wait_resp(2);
    send(2'b01, 7'd6, 64'h2B, 64'h01, -1, 1'b1, 1'b0);
    wait_resp(3);
    send(2'b10, 7'd64, 64'hDEAD_BEEF_0123_4567, 64'h1234_5678_9ABC_DEF1, -1, 1'b1, 1'b0);
    wait_resp(4);
    chk("idcode_bit0", 128'(resp_data[0]), 128'(1));

    // Length clamp and no-op.
    send(2'b10, 7'd0, 64'h1, 64'h1, -1, 1'b1, 1'b0);
    wait_resp(5);
    send(2'b10, 7'd100, 64'hF0F0_0F0F_AAAA_5555, 64'h8000_0000_0000_0003, -1, 1'b1, 1'b0);
    wait_resp(6);
    send(2'b11, 7'd5, 64'h7, 64'h0, -1, 1'b1, 1'b0);
    wait_resp(7);

    // Back-to-back with cmd_valid held.
    send(2'b10, 7'd8, 64'h96, 64'h5A, -1, 1'b1, 1'b1);
    send(2'b10, 7'd5, 64'h13, 64'h0E, -1, 1'b1, 1'b0);
    chk("b2b_accept_cycle", 128'(acc_cyc), 128'(resp_cyc));
    wait_resp(9);

    // TDO enable low on one scan sample, then cleared by the next scan.
    send(2'b10, 7'd8, 64'hC3, 64'h81, 5, 1'b1, 1'b0);
    wait_resp(10);
    send(2'b10, 7'd4, 64'h9, 64'h6, -1, 1'b1, 1'b0);
    wait_resp(11);

    // Reset during the third scan bit of a DR walk.
    send(2'b10, 7'd8, 64'hFF, 64'hFF, -1, 1'b0, 1'b0);
    for (int i = 0; i < 300 && rise_cnt < 6; i++) @(negedge clk);
    chk("rst_reach_bit3", 128'(rise_cnt), 128'(6));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tck", 128'(jtag_clk), 128'(0));
    chk("abort_tms", 128'(jtag_modesel), 128'(1));
    chk("abort_tdi", 128'(jtag_datain), 128'(0));
    chk("abort_ready", 128'(cmd_ready), 128'(1));
    chk("abort_valid", 128'(resp_valid), 128'(0));
    rst = 1'b0;
    last_data = '0;
    last_err = 1'b0;
    rc = rise_cnt;
    rr = resp_cnt;
    repeat (40) @(negedge clk);
    chk("abort_no_tck", 128'(rise_cnt), 128'(rc));
    chk("abort_no_resp", 128'(resp_cnt), 128'(rr));
    send(2'b00, 7'd0, '0, '0, -1, 1'b1, 1'b0);
    wait_resp(rr + 1);
    send(2'b10, 7'd8, 64'h3C, 64'hA5, -1, 1'b1, 1'b0);
    wait_resp(rr + 2);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
